// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: valid/ready flow controller that steers one held word to one of n output channels.
// Optional stall timeout enabled by DEMUX_DISPATCH_TIMEOUT_EN (adds TIMEOUT and timeoutPulse).
module demux_dispatch_ctrl #(
    parameter int n = 4,
    parameter int logn = $clog2(n),
    parameter int W = 8
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inValid,
    output logic            inReady,
    input  logic [W-1:0]    inData,
    input  logic [logn-1:0] inDest,
    input  logic            modeRR,
    output logic [n-1:0]    outValid,
    input  logic [n-1:0]    outReady,
    output logic [W-1:0]    outData,
    output logic [logn-1:0] outSel,
    output logic [7:0]      dropCount,
    output logic            busy
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    , output logic          timeoutPulse
`endif
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [logn-1:0] rr_ptr;
    logic            rr_mode;
    logic            sel_ready;
    logic            xfer;
    logic            timeout_hit;
    logic            release_word;
    logic            accept;
    logic            illegal;
    logic [logn-1:0] next_ptr;
    logic [logn-1:0] dest;
    logic [8:0]      drop_sum;

    function automatic logic [n-1:0] onehot(input logic [logn-1:0] s);
        return {{(n-1){1'b0}}, 1'b1} << s;
    endfunction

    // masked OR avoids indexing outReady with a select wider than the channel range
    assign sel_ready    = |(outReady & onehot(outSel));
    assign xfer         = state == HOLD && sel_ready;
    assign release_word = xfer || timeout_hit;
    assign inReady      = resetn && (state == IDLE || release_word);
    assign accept       = inValid && inReady;
    assign illegal      = !modeRR && {1'b0, inDest} >= (logn+1)'(n);
    assign next_ptr     = release_word && rr_mode
                          ? (outSel == logn'(n-1) ? '0 : outSel + 1'b1)
                          : rr_ptr;
    assign dest         = modeRR ? next_ptr : inDest;
    assign drop_sum     = 9'(dropCount) + 9'(accept && illegal) + 9'(timeout_hit);

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall_cnt;

    assign timeout_hit  = state == HOLD && !sel_ready && stall_cnt == CW'(TIMEOUT - 1);
    assign timeoutPulse = timeout_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt <= '0;
        else if (accept || timeout_hit || state != HOLD || sel_ready)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + CW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rr_mode   <= 1'b0;
            outValid  <= '0;
            outData   <= '0;
            outSel    <= '0;
            dropCount <= '0;
            busy      <= 1'b0;
        end else begin
            rr_ptr    <= next_ptr;
            dropCount <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (accept && !illegal) begin
                state    <= HOLD;
                outData  <= inData;
                outSel   <= dest;
                rr_mode  <= modeRR;
                outValid <= onehot(dest);
                busy     <= 1'b1;
            end else if (inReady) begin
                state    <= IDLE;
                outValid <= '0;
                busy     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: self-checking bench with a transaction-level reference model.
module tb_demux_dispatch_ctrl;
    localparam int N = 4;
    localparam int LN = 2;
    localparam int W = 8;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int TMO = 4;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic in_valid, in_ready, mode_rr;
    logic [W-1:0] in_data, out_data;
    logic [LN-1:0] in_dest, out_sel;
    logic [N-1:0] out_valid, out_ready;
    logic [7:0] drop_count;
    logic busy, timeout_pulse;

    logic v1, rdy1, mode1, busy1, tp1;
    logic [W-1:0] data1, odata1;
    logic [1:0] dest1, sel1;
    logic [2:0] ovalid1, oready1;
    logic [7:0] drop1;

    int checks = 0;
    int errors = 0;

    bit m_held;
    int m_data, m_sel, m_ptr, m_drops, m_stall;
    bit m_rr;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.n(N), .W(W)
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .resetn(resetn), .inValid(in_valid), .inReady(in_ready),
        .inData(in_data), .inDest(in_dest), .modeRR(mode_rr), .outValid(out_valid),
        .outReady(out_ready), .outData(out_data), .outSel(out_sel),
        .dropCount(drop_count), .busy(busy)
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        , .timeoutPulse(timeout_pulse)
`endif
    );

    demux_dispatch_ctrl #(.n(3), .W(W)) dut3 (
        .clk(clk), .resetn(resetn), .inValid(v1), .inReady(rdy1),
        .inData(data1), .inDest(dest1), .modeRR(mode1), .outValid(ovalid1),
        .outReady(oready1), .outData(odata1), .outSel(sel1),
        .dropCount(drop1), .busy(busy1)
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        , .timeoutPulse(tp1)
`endif
    );

`ifndef DEMUX_DISPATCH_TIMEOUT_EN
    assign timeout_pulse = 1'b0;
    assign tp1 = 1'b0;
`endif

    function automatic bit stalled();
        return m_held && !out_ready[m_sel];
    endfunction

    function automatic bit exp_ready();
        bit r;
        r = !m_held || out_ready[m_sel];
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        if (stalled() && m_stall == TMO - 1) r = 1;
`endif
        return r;
    endfunction

    // advances the reference model by one clock edge using the current inputs
    task automatic model_edge();
        bit rdy, to, gone;
        rdy = exp_ready();
        to = 0;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        if (stalled()) begin
            m_stall++;
            to = m_stall == TMO;
        end
`endif
        gone = m_held && (out_ready[m_sel] || to);
        if (to) m_drops = m_drops < 255 ? m_drops + 1 : 255;
        if (gone && m_rr) m_ptr = (m_sel + 1) % N;
        if (gone) m_held = 0;
        if (in_valid && rdy) begin
            m_held = 1;
            m_data = in_data;
            m_sel = mode_rr ? m_ptr : in_dest;
            m_rr = mode_rr;
            m_stall = 0;
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_drops = 0; m_stall = 0; m_rr = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        model_reset();
        in_valid = 1; in_dest = 2; in_data = 8'h3C; mode_rr = 0; out_ready = '0;
        tick();
        in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 4'b0100) begin errors++; $display("FAIL reset_pre_hold outValid got %b want 0100", out_valid); end
        #2 resetn = 0;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_outvalid got %b want 0000", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_inready got %b want 0", in_ready); end
        checks++;
        if (drop_count !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_drop_busy got %0d/%b want 0/0", drop_count, busy); end
        @(posedge clk);
        #1 resetn = 1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_inready got %b want 1", in_ready); end
        checks++;
        if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_release_outsel got %0d want 0", out_sel); end
    endtask

    task automatic test_directed();
        out_ready = '1; mode_rr = 0; in_dest = 2; in_data = 8'hA5; in_valid = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_inready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 4'b0100 || out_data !== 8'hA5) begin errors++; $display("FAIL dir_present got %b/%h want 0100/a5", out_valid, out_data); end
        checks++;
        if (busy !== 1'b1 || out_sel !== 2'd2) begin errors++; $display("FAIL dir_busy_sel got %b/%0d want 1/2", busy, out_sel); end
        tick();
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir_idle got %b/%b/%b want 0000/0/1", out_valid, busy, in_ready); end
    endtask

    task automatic test_back_to_back();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        out_ready = '1; mode_rr = 1; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i + 1);
            in_dest = 2'(3 - (i % 4));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_inready word %0d got %b want 1", i + 1, in_ready); end
            tick();
            checks++;
            if (out_sel !== 2'(seq[i]) || out_data !== 8'(i + 1) || out_valid !== 4'(1 << seq[i]))
                begin errors++; $display("FAIL rr_word %0d got sel %0d data %0d valid %b want sel %0d data %0d", i + 1, out_sel, out_data, out_valid, seq[i], i + 1); end
        end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL rr_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_stall();
        mode_rr = 0; in_dest = 3; in_data = 8'h5A; in_valid = 1; out_ready = '1;
        tick();
        in_valid = 1; in_data = 8'hFF; in_dest = 0; mode_rr = 1; out_ready = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (out_valid !== 4'b1000 || out_data !== 8'h5A || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_cycle %0d got %b/%h/%b want 1000/5a/0", k, out_valid, out_data, in_ready); end
            tick();
        end
        in_valid = 0; out_ready = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b1000) begin errors++; $display("FAIL stall_release got %b/%b want 1/1000", in_ready, out_valid); end
        tick();
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL stall_done got %b/%b want 0000/0", out_valid, busy); end
    endtask

    task automatic test_illegal_dest();
        in_valid = 0; out_ready = '1;
        checks++;
        if (drop1 !== 8'd0) begin errors++; $display("FAIL illegal_initial got %0d want 0", drop1); end
        v1 = 1; mode1 = 0; dest1 = 3; data1 = 8'h99; oready1 = '1;
        #1;
        checks++;
        if (rdy1 !== 1'b1) begin errors++; $display("FAIL illegal_inready got %b want 1", rdy1); end
        tick();
        checks++;
        if (drop1 !== 8'd1 || ovalid1 !== 3'b000 || busy1 !== 1'b0) begin errors++; $display("FAIL illegal_first got %0d/%b want 1/000", drop1, ovalid1); end
        for (int i = 1; i < 300; i++) tick();
        checks++;
        if (drop1 !== 8'd255 || ovalid1 !== 3'b000) begin errors++; $display("FAIL illegal_saturate got %0d/%b want 255/000", drop1, ovalid1); end
        dest1 = 1; data1 = 8'h77;
        tick();
        v1 = 0;
        checks++;
        if (ovalid1 !== 3'b010 || odata1 !== 8'h77) begin errors++; $display("FAIL illegal_then_legal got %b/%h want 010/77", ovalid1, odata1); end
        tick();
        checks++;
        if (ovalid1 !== 3'b000 || drop1 !== 8'd255) begin errors++; $display("FAIL illegal_legal_done got %b/%0d want 000/255", ovalid1, drop1); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 9) < 7;
            in_data = 8'($urandom);
            in_dest = 2'($urandom);
            mode_rr = 1'($urandom);
            out_ready = 4'($urandom);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_inready cyc %0d got %b want %b", c, in_ready, exp_ready()); end
            tick();
            checks++;
            if (out_valid !== (m_held ? 4'(1 << m_sel) : 4'b0000) || busy !== m_held)
                begin errors++; $display("FAIL rand_valid cyc %0d got %b/%b want held %b sel %0d", c, out_valid, busy, m_held, m_sel); end
            checks++;
            if (out_data !== 8'(m_data) || out_sel !== 2'(m_sel))
                begin errors++; $display("FAIL rand_data cyc %0d got %h/%0d want %h/%0d", c, out_data, out_sel, m_data, m_sel); end
            checks++;
            if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL rand_drop cyc %0d got %0d want %0d", c, drop_count, m_drops); end
        end
        in_valid = 0; out_ready = '1;
        tick();
        tick();
    endtask

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        base = m_drops;
        mode_rr = 0; in_dest = 1; in_data = 8'h11; in_valid = 1; out_ready = '0;
        tick();
        in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (timeout_pulse !== (k == 4) || in_ready !== (k == 4))
                begin errors++; $display("FAIL timeout_cycle %0d got pulse %b ready %b want %b", k, timeout_pulse, in_ready, k == 4); end
            tick();
        end
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || timeout_pulse !== 1'b0)
            begin errors++; $display("FAIL timeout_idle got %b/%b/%b want 0000/0/0", out_valid, busy, timeout_pulse); end
        checks++;
        if (drop_count !== 8'(base < 255 ? base + 1 : 255)) begin errors++; $display("FAIL timeout_drop got %0d want %0d", drop_count, base + 1); end
    endtask
`endif

    initial begin
        in_valid = 0; in_data = '0; in_dest = '0; mode_rr = 0; out_ready = '0;
        v1 = 0; data1 = '0; dest1 = '0; mode1 = 0; oready1 = '0;
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_illegal_dest();
        test_random();
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Flow controller that sequences a 1-to-n demultiplexer datapath.
- Accepts one word at a time from a single valid/ready input stream and holds it in a one-entry register.
- Steers the word to exactly one of n output channels, each with its own valid/ready pair.
- Destination comes from the input's destination field (directed mode) or from an internal round-robin pointer.

Parameters:
- n, 4, number of output channels (n >= 2).
- logn, $clog2(n), width of the channel select field.
- W, 8, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- inValid  input  1  input word valid.
- inReady  output  1  controller can accept a word this cycle.
- inData  input  W  input word.
- inDest  input  logn  destination channel, used in directed mode.
- modeRR  input  1  1 = round-robin, 0 = directed; sampled only at accept.
- outValid  output  n  one-hot per-channel valid.
- outReady  input  n  per-channel ready.
- outData  output  W  held word, shared by all channels.
- outSel  output  logn  index of the currently selected channel.
- dropCount  output  8  count of dropped words, saturating.
- busy  output  1  high while in HOLD.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values, applied immediately while resetn = 0:
  - state = IDLE; rrPtr = 0; outValid = 0; outData = 0; outSel = 0; dropCount = 0; busy = 0.
  - inReady = 0 while resetn is low.
- States:
  - IDLE: empty. inReady = 1, outValid = 0.
  - HOLD: word held. outValid = one-hot(outSel), busy = 1.
- Accept occurs when inValid && inReady. On accept:
  - outData <= inData.
  - outSel <= modeRR ? rrPtr : inDest.
  - state <= HOLD.
- Latency: a word accepted at edge t is presented (outValid asserted) in the cycle after edge t.
- Transfer occurs in HOLD when outReady[outSel] = 1 at the edge:
  - If modeRR was set at accept, rrPtr <= (outSel + 1) mod n. Wrap-around: n-1 -> 0, also for non-power-of-2 n.
  - In directed mode rrPtr is unchanged.
- inReady rule: inReady = (state == IDLE) || (state == HOLD && outReady[outSel]).
  - Transfer plus accept in the same cycle: stay in HOLD with the new word, giving one word per clock throughput.
  - In round-robin mode the new word uses the advanced pointer value.
- Stall: in HOLD with outReady[outSel] = 0:
  - outData, outSel and outValid are held stable.
  - Readiness of non-selected channels is ignored.
- Transfer without a new accept: state <= IDLE, outValid = 0.
- Illegal destination: directed mode with inDest >= n (only possible for non-power-of-2 n):
  - The word is accepted and discarded; state remains or returns to IDLE.
  - dropCount increments, saturating at 255.
- modeRR changes while in HOLD have no effect on the held word.
- Reset mid-operation: the held word is lost, outputs return to reset values, and no partial handshake completes.

Optional Feature:
- Macro: DEMUX_DISPATCH_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT (default 16) and output timeoutPulse (1 bit).
  - A stall counter clears on every accept and counts cycles spent in HOLD without a transfer.
  - On reaching TIMEOUT, the held word is dropped:
    - state <= IDLE, or accept a new word if inValid; inReady = 1 that cycle.
    - timeoutPulse = 1 for one cycle.
    - dropCount increments, saturating.
  - rrPtr still advances, so the round-robin pointer skips the dead channel.
- Undefined: no counter and no port; HOLD persists indefinitely.

Test Plan:
- Reset: assert resetn = 0 mid-HOLD with outValid = 4'b0100 -> outValid = 0, inReady = 0 and dropCount = 0 immediately; after release, inReady = 1 and outSel = 0.
- Directed: n = 4, modeRR = 0, send 8'hA5 with dest 2, all outReady = 1 -> outValid = 4'b0100 and outData = 8'hA5 one cycle after accept; transfer completes; IDLE.
- Round-robin wrap: modeRR = 1, all outReady = 1, inValid held for 6 words 1..6 -> outSel sequence 0,1,2,3,0,1, one word per clock, inReady constantly 1.
- Stall: dest 3, outReady = 4'b0111 for 5 cycles, then 4'b1000 -> outValid = 4'b1000 and data stable for 5 cycles, inReady = 0; transfer on cycle 6.
- Illegal destination: n = 3, directed, inDest = 3 -> word dropped, dropCount = 1, outValid stays 0; 300 such words -> dropCount = 255.
- Timeout (macro defined, TIMEOUT = 4): dest 1 with outReady = 0 -> timeoutPulse high once at the 4th stalled cycle, state IDLE, dropCount = 1.
